// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared BCD definitions for the digit-serial arithmetic path:
//                digit width, radix, largest legal digit, the sequencer state
//                encoding and a nibble legality helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_RADIX     = 10;
    localparam int BCD_MAX_DIGIT = 9;

    // Sequencer states shared by the serial subtractor and future serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bcd_seq_state_t;

    // True when a nibble does not encode a decimal digit.
    function automatic logic nibble_invalid(input logic [BCD_DIGIT_W-1:0] n);
        return n > BCD_DIGIT_W'(BCD_MAX_DIGIT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_subtractor_serial_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_subtractor_serial_if
//  Description : Start/busy/done bundle of the serial BCD subtractor.
//                master : controller (drives start, a, b, bin)
//                slave  : subtractor (drives busy, done, d, bout, invalid)
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_subtractor_serial_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
);
    logic                          start;
    logic [BCD_DIGIT_W*DIGITS-1:0] a;
    logic [BCD_DIGIT_W*DIGITS-1:0] b;
    logic                          bin;
    logic                          busy;
    logic                          done;
    logic [BCD_DIGIT_W*DIGITS-1:0] d;
    logic                          bout;
    logic                          invalid;

    modport master (
        output start, a, b, bin,
        input  busy, done, d, bout, invalid
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, d, bout, invalid
    );
endinterface
`default_nettype wire

// File: rtl/bcd_digit_sub.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_sub
//  Description : Combinational single BCD digit subtract, diff = x - y - bi
//                with ten's-complement correction on borrow.
//  Ports       : x, y  - 4-bit digits
//                bi    - borrow in
//                diff  - 4-bit result digit
//                bo    - borrow out
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  wire logic [BCD_DIGIT_W-1:0] x,
    input  wire logic [BCD_DIGIT_W-1:0] y,
    input  wire logic                   bi,
    output logic      [BCD_DIGIT_W-1:0] diff,
    output logic                        bo
);
    // The difference spans -16..15 even for illegal nibbles, so a 5-bit
    // two's-complement value is exact and its MSB is the sign.
    logic [BCD_DIGIT_W:0] w_t;

    assign w_t  = {1'b0, x} - {1'b0, y} - {{BCD_DIGIT_W{1'b0}}, bi};
    assign bo   = w_t[BCD_DIGIT_W];
    assign diff = w_t[BCD_DIGIT_W-1:0]
                + (bo ? BCD_DIGIT_W'(BCD_RADIX) : {BCD_DIGIT_W{1'b0}});
endmodule
`default_nettype wire

// File: rtl/bcd_subtractor_serial.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_subtractor_serial
//  Description : Digit-serial multi-digit BCD subtractor, d = a - b - bin,
//                one digit per clock, least-significant digit first.
//  Ports       : clk, rst - clock, synchronous active-high reset
//                bus      - slave side of bcd_subtractor_serial_if
//                           (start/a/b/bin in; busy/done/d/bout/invalid out)
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_subtractor_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
)(
    input  wire logic             clk,
    input  wire logic             rst,
    bcd_subtractor_serial_if.slave bus
);
    localparam int c_width = BCD_DIGIT_W * DIGITS;
    localparam int c_cnt_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIGITS - 1);

    bcd_seq_state_t       r_state;
    bcd_seq_state_t       w_state_next;

    logic [c_width-1:0]   r_a;
    logic [c_width-1:0]   r_b;
    logic                 r_borrow;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_width-1:0]   r_d;
    logic                 r_bout;
    logic                 r_invalid;
    logic                 r_busy;
    logic                 r_done;

    logic [BCD_DIGIT_W-1:0] w_x;
    logic [BCD_DIGIT_W-1:0] w_y;
    logic [BCD_DIGIT_W-1:0] w_diff;
    logic                   w_bo;
    logic                   w_last;
    logic                   w_in_invalid;

    assign w_last = (r_cnt == c_last);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------ digit select / check
    always_comb begin
        w_x = '0;
        w_y = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_cnt == c_cnt_w'(i)) begin
                w_x = r_a[i*BCD_DIGIT_W +: BCD_DIGIT_W];
                w_y = r_b[i*BCD_DIGIT_W +: BCD_DIGIT_W];
            end
        end
    end

    always_comb begin
        w_in_invalid = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            w_in_invalid = w_in_invalid
                         | nibble_invalid(bus.a[i*BCD_DIGIT_W +: BCD_DIGIT_W])
                         | nibble_invalid(bus.b[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
        end
    end

    bcd_digit_sub u_digit_sub (
        .x    (w_x),
        .y    (w_y),
        .bi   (r_borrow),
        .diff (w_diff),
        .bo   (w_bo)
    );

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_borrow  <= 1'b0;
            r_cnt     <= '0;
            r_d       <= '0;
            r_bout    <= 1'b0;
            r_invalid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // Status flags follow the next state so they stay registered
            // yet line up with the state they describe.
            r_busy <= (w_state_next != IDLE);
            r_done <= (w_state_next == DONE);
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a       <= bus.a;
                        r_b       <= bus.b;
                        r_borrow  <= bus.bin;
                        r_cnt     <= '0;
                        r_invalid <= w_in_invalid;
                        r_d       <= '0;
                        r_bout    <= 1'b0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (r_cnt == c_cnt_w'(i)) begin
                            r_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] <= w_diff;
                        end
                    end
                    r_borrow <= w_bo;
                    if (w_last) begin
                        r_bout <= w_bo;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.d       = r_d;
    assign bus.bout    = r_bout;
    assign bus.invalid = r_invalid;
endmodule
`default_nettype wire

// File: tb/tb_bcd_subtractor_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_subtractor_serial
//  Description : Scoreboard bench for bcd_subtractor_serial (DIGITS = 2).
//                Stimulus pushes hand-computed results; a negedge monitor
//                pops one entry per done pulse and compares it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_subtractor_serial;
    localparam int DIGITS = 2;

    typedef struct {
        logic [7:0] d;
        logic       bout;
        logic       inv;
        int         due;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_subtractor_serial_if #(.DIGITS(DIGITS)) bus ();

    bcd_subtractor_serial #(.DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------ monitor
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, required no pending operation", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_d"},       32'(bus.d),       32'(e.d));
                chk({e.name, "_bout"},    32'(bus.bout),    32'(e.bout));
                chk({e.name, "_invalid"}, 32'(bus.invalid), 32'(e.inv));
                chk({e.name, "_cycle"},   32'(cyc),         32'(e.due));
                chk({e.name, "_busy"},    32'(bus.busy),    32'd1);
            end
        end
    end

    // ----------------------------------------------------------- stimulus
    task automatic push_exp(input string name, input logic [7:0] ed,
                            input logic eb, input logic ei);
        exp_t e;
        e.name = name;
        e.d    = ed;
        e.bout = eb;
        e.inv  = ei;
        e.due  = cyc + DIGITS;   // called right after edge 0
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%b, required 0", bus.busy);
        end
    endtask

    task automatic issue(input string name, input logic [7:0] ia, input logic [7:0] ib,
                         input logic ibin, input logic [7:0] ed, input logic eb,
                         input logic ei);
        wait_idle();
        bus.a     = ia;
        bus.b     = ib;
        bus.bin   = ibin;
        bus.start = 1'b1;
        @(posedge clk); #1;          // edge 0
        bus.start = 1'b0;
        push_exp(name, ed, eb, ei);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: %0d results pending, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_done",    32'(bus.done),    32'd0);
        chk("rst_d",       32'(bus.d),       32'd0);
        chk("rst_bout",    32'(bus.bout),    32'd0);
        chk("rst_invalid", 32'(bus.invalid), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue("eq49",   8'h49, 8'h49, 1'b0, 8'h00, 1'b0, 1'b0); wait_done();
        issue("s21_11", 8'h21, 8'h11, 1'b0, 8'h10, 1'b0, 1'b0); wait_done();
        repeat (3) @(posedge clk);
        #1;
        chk("hold_d",    32'(bus.d),    32'h10);
        chk("hold_busy", 32'(bus.busy), 32'd0);
        issue("s91_09", 8'h91, 8'h09, 1'b0, 8'h82, 1'b0, 1'b0); wait_done();
        issue("s11_21", 8'h11, 8'h21, 1'b0, 8'h90, 1'b1, 1'b0); wait_done();
        issue("s00_b1", 8'h00, 8'h00, 1'b1, 8'h99, 1'b1, 1'b0); wait_done();
        issue("s38_12", 8'h38, 8'h12, 1'b1, 8'h25, 1'b0, 1'b0); wait_done();
        issue("inv1a",  8'h1A, 8'h05, 1'b0, 8'h15, 1'b0, 1'b1); wait_done();
        issue("s50_25", 8'h50, 8'h25, 1'b0, 8'h25, 1'b0, 1'b0); wait_done();

        // start and operand changes while RUN must be ignored
        issue("busyign", 8'h63, 8'h27, 1'b0, 8'h36, 1'b0, 1'b0);
        bus.start = 1'b1;
        bus.a     = 8'h99;
        bus.b     = 8'h00;
        bus.bin   = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done();
        repeat (4) @(posedge clk);
        #1;
        chk("busyign_hold_d", 32'(bus.d), 32'h36);

        // back-to-back: start held from the DONE cycle, accepted on the next IDLE edge
        issue("b2b_first", 8'h80, 8'h01, 1'b0, 8'h79, 1'b0, 1'b0);
        begin
            int n;
            n = 0;
            while (bus.done !== 1'b1 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
        end
        bus.a     = 8'h45;
        bus.b     = 8'h45;
        bus.bin   = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;          // edge leaving DONE
        chk("b2b_idle_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;          // first IDLE edge: accepted
        bus.start = 1'b0;
        chk("b2b_accept_busy", 32'(bus.busy), 32'd1);
        push_exp("b2b_second", 8'h99, 1'b1, 1'b0);
        wait_done();

        // reset in the cycle after the start edge aborts the operation
        wait_idle();
        bus.a     = 8'hAA;
        bus.b     = 8'h00;
        bus.bin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("abort_inv_latched", 32'(bus.invalid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy",    32'(bus.busy),    32'd0);
        chk("abort_done",    32'(bus.done),    32'd0);
        chk("abort_d",       32'(bus.d),       32'd0);
        chk("abort_bout",    32'(bus.bout),    32'd0);
        chk("abort_invalid", 32'(bus.invalid), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        issue("after_rst", 8'h07, 8'h04, 1'b0, 8'h03, 1'b0, 1'b0); wait_done();

        repeat (4) @(posedge clk);
        #1;
        chk("pending_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bcd_subtractor_serial.md
# bcd_subtractor_serial

Digit-serial multi-digit BCD subtractor computing `a - b - bin`, one BCD digit per clock, least-significant digit first. It is the subtraction counterpart of the team's BCD adder path and shares the same packed-BCD operand format. A start/busy/done handshake lets a controller issue operations and collect results.

## Interface
- `DIGITS`, default 2: number of BCD digits per operand; must be ≥1.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: request an operation; sampled only in IDLE.
- `a`  in  4*DIGITS: minuend, packed BCD, digit 0 in bits [3:0].
- `b`  in  4*DIGITS: subtrahend, packed BCD.
- `bin`  in  1: borrow-in.
- `busy`  out  1: high in RUN and DONE.
- `done`  out  1: one-cycle pulse; the result is valid from this cycle.
- `d`  out  4*DIGITS: difference, packed BCD.
- `bout`  out  1: final borrow. When 1, `d` is the ten's-complement result.
- `invalid`  out  1: at least one latched operand nibble was greater than 9.

## Operation
- States are IDLE, RUN and DONE. Reset forces IDLE and sets `busy=0`, `done=0`, `d=0`, `bout=0`, `invalid=0` and the digit counter to 0.
- IDLE, on a clock edge with `start=1`:
  - latch `a` and `b`; set the internal borrow to `bin`;
  - set `cnt=0`;
  - set `invalid` to the OR of (nibble > 9) over all nibbles of `a` and `b`;
  - clear `d` and `bout`;
  - go to RUN.
- RUN, on each edge, for digit i = `cnt`:
  - compute t = a_i − b_i − borrow as a signed 6-bit value;
  - if t < 0: d_i = (t + 10)[3:0] and borrow = 1;
  - otherwise: d_i = t[3:0] and borrow = 0;
  - then `cnt++`.
- RUN exit: on the edge that processes digit DIGITS−1, latch `bout` = borrow and go to DONE.
- DONE: `done=1` for this single cycle, then go to IDLE.
- Holding: `d`, `bout` and `invalid` keep their values until the next accepted `start` or reset.
- Busy behaviour: `start` while busy is ignored and does not queue. Operand changes while busy have no effect.
- Invalid operands: computation proceeds with the same rule and 4-bit truncation. No error state exists.
- Reset mid-operation: abort immediately, all outputs return to reset values, and no `done` is issued.
- Counter width: `cnt` is $clog2(DIGITS) bits (at least 1). It never wraps past DIGITS−1.

## Timing
- Call the edge that samples `start` edge 0. Digits are written on edges 1..DIGITS.
- `done` is high in the cycle following edge DIGITS, i.e. after DIGITS+1 edges counted from edge 0.
- `busy` rises after edge 0 and falls after the edge that ends DONE.
- Back-to-back operation: a new `start` is accepted on the first IDLE edge after DONE. Minimum issue interval is DIGITS+2 cycles.
- `d` is updated digit by digit during RUN, so it is only guaranteed complete when `done=1`.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `bcd_pkg` holds:
  - `BCD_DIGIT_W = 4`;
  - `BCD_RADIX = 10`;
  - `BCD_MAX_DIGIT = 9`;
  - the state enum `bcd_seq_state_t` {IDLE, RUN, DONE}, which is reusable by a future serial adder.
- Sub-module `bcd_digit_sub`: combinational single-digit subtract with ports `x[3:0]`, `y[3:0]`, `bi` → `diff[3:0]`, `bo`. It is instantiated once, and its inputs are muxed by `cnt`.
- The top level holds the FSM, digit counter, operand registers, borrow register and result register.

## Test plan
- a=0x49, b=0x49, bin=0 → d=0x00, bout=0, invalid=0; `done` exactly 3 cycles after the `start` edge.
- a=0x21, b=0x11, bin=0 → d=0x10, bout=0. Also a=0x91, b=0x09 → d=0x82, bout=0.
- a=0x11, b=0x21, bin=0 → d=0x90, bout=1. Also a=0x00, b=0x00, bin=1 → d=0x99, bout=1.
- a=0x1A, b=0x05 → invalid=1 and `done` still pulses once. Then a valid operation clears `invalid`.
- `start` re-asserted and operands changed during RUN → no effect; exactly one `done` with the original result. A `start` on the first IDLE cycle after DONE is accepted.
- `rst` asserted in the cycle after the start edge → all outputs 0 after that edge, no `done`. A subsequent operation a=0x07, b=0x04 → d=0x03.
